// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: op codes, FSM states and reset/zero constants.
package mem_access_pkg;

   localparam logic        RstEnable  = 1'b1;
   localparam logic [31:0] ZeroWord   = 32'h0000_0000;
   localparam logic [4:0]  NOPRegAddr = 5'b00000;

   localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
   localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
   localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      DONE = 2'b10
   } mem_state_e;

endpackage

// File: rtl/mem_lane.sv
// Big-endian byte-lane logic: bus sel/wdata generation for stores, extension for loads.
module mem_lane
   import mem_access_pkg::*;
(
   input  logic [7:0]  aluop,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] sdata,
   input  logic [31:0] rdata,
   output logic [3:0]  sel_c,
   output logic [31:0] wdata_c,
   output logic [31:0] ldata_c,
   output logic        mem_op_c,
   output logic        store_c,
   output logic        misalign_c
);

   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   // Lane 0 of the address is the most significant byte of the word.
   always_comb begin
      case (addr_lo)
         2'b00:   rbyte = rdata[31:24];
         2'b01:   rbyte = rdata[23:16];
         2'b10:   rbyte = rdata[15:8];
         default: rbyte = rdata[7:0];
      endcase
      rhalf = addr_lo[1] ? rdata[15:0] : rdata[31:16];
   end

   always_comb begin
      sel_c      = 4'b0000;
      wdata_c    = sdata;
      ldata_c    = rdata;
      mem_op_c   = 1'b1;
      store_c    = 1'b0;
      misalign_c = 1'b0;
      case (aluop)
         EXE_LB_OP: begin
            sel_c   = 4'b1000 >> addr_lo;
            ldata_c = {{24{rbyte[7]}}, rbyte};
         end
         EXE_LBU_OP: begin
            sel_c   = 4'b1000 >> addr_lo;
            ldata_c = {24'h000000, rbyte};
         end
         EXE_LH_OP: begin
            sel_c      = addr_lo[1] ? 4'b0011 : 4'b1100;
            ldata_c    = {{16{rhalf[15]}}, rhalf};
            misalign_c = addr_lo[0];
         end
         EXE_LHU_OP: begin
            sel_c      = addr_lo[1] ? 4'b0011 : 4'b1100;
            ldata_c    = {16'h0000, rhalf};
            misalign_c = addr_lo[0];
         end
         EXE_LW_OP: begin
            sel_c      = 4'b1111;
            misalign_c = |addr_lo;
         end
         EXE_SB_OP: begin
            sel_c   = 4'b1000 >> addr_lo;
            wdata_c = {4{sdata[7:0]}};
            store_c = 1'b1;
         end
         EXE_SH_OP: begin
            sel_c      = addr_lo[1] ? 4'b0011 : 4'b1100;
            wdata_c    = {2{sdata[15:0]}};
            store_c    = 1'b1;
            misalign_c = addr_lo[0];
         end
         EXE_SW_OP: begin
            sel_c      = 4'b1111;
            store_c    = 1'b1;
            misalign_c = |addr_lo;
         end
         default: mem_op_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: passes ALU results through and runs loads/stores over a req/ack bus.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        mem_wd,
   input  logic              mem_wreg,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic [7:0]        mem_aluop,
   input  logic [31:0]       mem_addr,
   input  logic [DATA_W-1:0] mem_sdata,
   output logic [4:0]        wb_wd,
   output logic              wb_wreg,
   output logic [DATA_W-1:0] wb_wdata,
   output logic              stallreq,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic              excp_misalign,
`endif
   output logic              dbus_req,
   output logic              dbus_we,
   output logic [ADDR_W-1:0] dbus_addr,
   output logic [3:0]        dbus_sel,
   output logic [DATA_W-1:0] dbus_wdata,
   input  logic              dbus_ack,
   input  logic [DATA_W-1:0] dbus_rdata
);

   mem_state_e        state_q, state_d;
   logic              req_d, we_d;
   logic [ADDR_W-1:0] addr_d;
   logic [3:0]        sel_d;
   logic [DATA_W-1:0] wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic [3:0]  sel_c;
   logic [31:0] wdata_c, ldata_c;
   logic        mem_op_c, store_c, misalign_c;
   logic        trap_c;

   mem_lane u_lane (
      .aluop      (mem_aluop),
      .addr_lo    (mem_addr[1:0]),
      .sdata      (mem_sdata),
      .rdata      (rdata_q),
      .sel_c      (sel_c),
      .wdata_c    (wdata_c),
      .ldata_c    (ldata_c),
      .mem_op_c   (mem_op_c),
      .store_c    (store_c),
      .misalign_c (misalign_c)
   );

`ifdef MEM_MISALIGN_TRAP_EN
   assign trap_c        = mem_op_c & misalign_c;
   assign excp_misalign = trap_c & (state_q == IDLE) & (rst != RstEnable);
`else
   logic unused_misalign;
   assign trap_c          = 1'b0;
   assign unused_misalign = misalign_c;
`endif

   // State and bus-side registers; the bus slave is reset alongside, so a lost ack is harmless.
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         state_q    <= IDLE;
         dbus_req   <= 1'b0;
         dbus_we    <= 1'b0;
         dbus_addr  <= '0;
         dbus_sel   <= 4'b0000;
         dbus_wdata <= ZeroWord;
         rdata_q    <= ZeroWord;
      end else begin
         state_q    <= state_d;
         dbus_req   <= req_d;
         dbus_we    <= we_d;
         dbus_addr  <= addr_d;
         dbus_sel   <= sel_d;
         dbus_wdata <= wdata_d;
         rdata_q    <= rdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      req_d    = dbus_req;
      we_d     = dbus_we;
      addr_d   = dbus_addr;
      sel_d    = dbus_sel;
      wdata_d  = dbus_wdata;
      rdata_d  = rdata_q;
      wb_wd    = mem_wd;
      wb_wreg  = mem_wreg;
      wb_wdata = mem_wdata;
      stallreq = 1'b0;
      case (state_q)
         IDLE: begin
            if (trap_c) begin
               wb_wreg = 1'b0;
            end else if (mem_op_c) begin
               stallreq = 1'b1;
               wb_wreg  = 1'b0;
               wb_wdata = ZeroWord;
               state_d  = WAIT;
               req_d    = 1'b1;
               we_d     = store_c;
               addr_d   = ADDR_W'({mem_addr[31:2], 2'b00});
               sel_d    = sel_c;
               wdata_d  = wdata_c;
            end
         end
         WAIT: begin
            stallreq = 1'b1;
            wb_wreg  = 1'b0;
            wb_wdata = ZeroWord;
            if (dbus_ack) begin
               rdata_d = dbus_rdata;
               req_d   = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
            // Always back to IDLE so the stalled instruction is not issued twice.
            state_d = IDLE;
            if (store_c) begin
               wb_wreg = 1'b0;
            end else if (mem_op_c) begin
               wb_wdata = ldata_c;
            end
         end
         default: state_d = IDLE;
      endcase
      if (rst == RstEnable) begin
         wb_wd    = NOPRegAddr;
         wb_wreg  = 1'b0;
         wb_wdata = ZeroWord;
         stallreq = 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: randomized ALU/load/store traffic against a lane model.
`timescale 1ns/1ps
module tb_mem_access;
   import mem_access_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  mem_wd = '0;
   logic        mem_wreg = 1'b0;
   logic [31:0] mem_wdata = '0;
   logic [7:0]  mem_aluop = EXE_OR_OP;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_sdata = '0;
   logic [4:0]  wb_wd;
   logic        wb_wreg;
   logic [31:0] wb_wdata;
   logic        stallreq;
   logic        dbus_req, dbus_we;
   logic [31:0] dbus_addr;
   logic [3:0]  dbus_sel;
   logic [31:0] dbus_wdata;
   logic        dbus_ack = 1'b0;
   logic [31:0] dbus_rdata = '0;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        excp_misalign;
`endif

   int tests = 0;
   int fails = 0;
   int req_rises = 0;
   logic req_prev = 1'b0;

   mem_access dut (
      .clk(clk), .rst(rst),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_aluop(mem_aluop), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
      .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata), .stallreq(stallreq),
`ifdef MEM_MISALIGN_TRAP_EN
      .excp_misalign(excp_misalign),
`endif
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
      .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
      .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dbus_req && !req_prev) req_rises++;
      req_prev = dbus_req;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic bit is_store(input logic [7:0] op);
      return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
   endfunction

   function automatic logic [3:0] ref_sel(input logic [7:0] op, input logic [31:0] a);
      int k, h;
      k = int'(a % 4);
      h = int'((a / 2) % 2);
      if (op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP}) return 4'(1 << (3 - k));
      if (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) return 4'(3 << (2 * (1 - h)));
      return 4'hF;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [7:0] op, input logic [31:0] s);
      if (op == EXE_SB_OP) return (s & 32'hFF) * 32'h0101_0101;
      if (op == EXE_SH_OP) return (s & 32'hFFFF) * 32'h0001_0001;
      return s;
   endfunction

   function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] a,
                                            input logic [31:0] r);
      int k, h, b, hw;
      k  = int'(a % 4);
      h  = int'((a / 2) % 2);
      b  = int'((r >> (8 * (3 - k))) & 32'hFF);
      hw = int'((r >> (16 * (1 - h))) & 32'hFFFF);
      case (op)
         EXE_LB_OP:  return 32'((b >= 128) ? b - 256 : b);
         EXE_LBU_OP: return 32'(b);
         EXE_LH_OP:  return 32'((hw >= 32768) ? hw - 65536 : hw);
         EXE_LHU_OP: return 32'(hw);
         default:    return r;
      endcase
   endfunction

   // One load/store from issue to DONE; nwait = number of WAIT cycles (ack in the last).
   task automatic mem_op(input string name, input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rdata, input int nwait);
      logic [4:0]  wd;
      logic [31:0] wdat, exp_wdata;
      logic        exp_wreg;
      int          stalls, waits;
      bit          done, st;
      wd = 5'($urandom);
      wdat = $urandom;
      st = is_store(op);
      mem_aluop = op; mem_addr = addr; mem_sdata = sdata;
      mem_wd = wd; mem_wreg = 1'b1; mem_wdata = wdat;
      #1;
      tests++;
      if (stallreq !== 1'b1 || dbus_req !== 1'b0) begin
         fails++;
         $display("FAIL %s issue: stallreq=%b dbus_req=%b, required 1 0", name, stallreq, dbus_req);
      end
      stalls = 0; waits = 0; done = 0;
      for (int c = 0; c < 64 && !done; c++) begin
         if (stallreq === 1'b1) stalls++;
         if (dbus_req === 1'b1) begin
            waits++;
            tests++;
            if (dbus_addr !== (addr & ~32'h3) || dbus_sel !== ref_sel(op, addr) ||
                dbus_we !== st || (st && dbus_wdata !== ref_wdata(op, sdata))) begin
               fails++;
               $display("FAIL %s bus: addr=%h sel=%b we=%b wdata=%h, required %h %b %b %h",
                        name, dbus_addr, dbus_sel, dbus_we, dbus_wdata, addr & ~32'h3,
                        ref_sel(op, addr), st, ref_wdata(op, sdata));
            end
            if (waits == nwait) begin
               dbus_ack = 1'b1;
               dbus_rdata = rdata;
            end
         end else if (c > 0 && stallreq === 1'b0) begin
            done = 1;
            exp_wdata = st ? wdat : ref_load(op, addr, rdata);
            exp_wreg = !st;
            tests++;
            if (wb_wd !== wd || wb_wreg !== exp_wreg || wb_wdata !== exp_wdata ||
                stalls != 1 + nwait) begin
               fails++;
               $display("FAIL %s done: wd=%0d wreg=%b wdata=%h stalls=%0d, required %0d %b %h %0d",
                        name, wb_wd, wb_wreg, wb_wdata, stalls, wd, exp_wreg, exp_wdata, 1 + nwait);
            end
         end
         if (!done) begin
            @(posedge clk); #1;
            dbus_ack = 1'b0;
            dbus_rdata = $urandom;
            #1;
         end
      end
      if (!done) begin
         tests++; fails++;
         $display("FAIL %s timeout: no DONE cycle within 64 cycles, required completion", name);
      end
      @(posedge clk); #1;
      mem_aluop = EXE_OR_OP;
   endtask

   function automatic logic [7:0] rand_load_op();
      case ($urandom_range(0, 4))
         0: return EXE_LB_OP;
         1: return EXE_LBU_OP;
         2: return EXE_LH_OP;
         3: return EXE_LHU_OP;
         default: return EXE_LW_OP;
      endcase
   endfunction

   function automatic logic [7:0] rand_store_op();
      case ($urandom_range(0, 2))
         0: return EXE_SB_OP;
         1: return EXE_SH_OP;
         default: return EXE_SW_OP;
      endcase
   endfunction

   function automatic logic [31:0] rand_addr(input logic [7:0] op);
      logic [31:0] a;
      a = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
      if (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) a = a & ~32'h1;
      if (op inside {EXE_LW_OP, EXE_SW_OP}) a = a & ~32'h3;
`endif
      return a;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      mem_aluop = EXE_LW_OP; mem_wd = 5'd7; mem_wreg = 1'b1; mem_wdata = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (wb_wd !== 5'd0 || wb_wreg !== 1'b0 || wb_wdata !== 32'h0 || stallreq !== 1'b0 ||
          dbus_req !== 1'b0 || dbus_we !== 1'b0 || dbus_addr !== 32'h0 || dbus_sel !== 4'h0 ||
          dbus_wdata !== 32'h0) begin
         fails++;
         $display("FAIL reset: wd=%0d wreg=%b wdata=%h stall=%b req=%b we=%b addr=%h sel=%b bw=%h, required all 0",
                  wb_wd, wb_wreg, wb_wdata, stallreq, dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata);
      end
      mem_aluop = EXE_OR_OP;
      rst = 1'b0;
      #1;
   endtask

   task automatic test_alu();
      int r0;
      logic [7:0] op;
      r0 = req_rises;
      for (int i = 0; i < 8; i++) begin
         op = (i == 0) ? EXE_OR_OP : 8'($urandom_range(0, 8'hDF));
         mem_aluop = op;
         mem_wd    = (i == 0) ? 5'd3 : 5'($urandom);
         mem_wreg  = (i == 0) ? 1'b1 : 1'($urandom);
         mem_wdata = (i == 0) ? 32'h1234 : $urandom;
         mem_addr  = $urandom;
         dbus_ack  = 1'($urandom);
         #1;
         tests++;
         if (wb_wd !== mem_wd || wb_wreg !== mem_wreg || wb_wdata !== mem_wdata || stallreq !== 1'b0) begin
            fails++;
            $display("FAIL alu op=%h: wd=%0d wreg=%b wdata=%h stall=%b, required %0d %b %h 0",
                     op, wb_wd, wb_wreg, wb_wdata, stallreq, mem_wd, mem_wreg, mem_wdata);
         end
         @(posedge clk); #1;
      end
      dbus_ack = 1'b0;
      tests++;
      if (req_rises != r0 || dbus_req !== 1'b0) begin
         fails++;
         $display("FAIL alu bus: req rises=%0d req=%b, required 0 0", req_rises - r0, dbus_req);
      end
   endtask

   task automatic test_loads();
      logic [7:0] op;
      mem_op("lb",  EXE_LB_OP,  32'h1001, 32'h0, 32'h8899_AABB, 2);
      mem_op("lbu", EXE_LBU_OP, 32'h1003, 32'h0, 32'h8899_AABB, 1);
      mem_op("lhu", EXE_LHU_OP, 32'h1002, 32'h0, 32'h8899_AABB, 1);
      mem_op("lh",  EXE_LH_OP,  32'h1000, 32'h0, 32'h8899_AABB, 3);
      for (int i = 0; i < 10; i++) begin
         op = rand_load_op();
         mem_op("rand_load", op, rand_addr(op), $urandom, $urandom, $urandom_range(1, 4));
      end
   endtask

   task automatic test_stores();
      logic [7:0] op;
      mem_op("sh", EXE_SH_OP, 32'h2002, 32'h1234_ABCD, 32'h0, 1);
      for (int i = 0; i < 8; i++) begin
         op = rand_store_op();
         mem_op("rand_store", op, rand_addr(op), $urandom, $urandom, $urandom_range(1, 3));
      end
   endtask

   task automatic test_back_to_back();
      int r0;
      r0 = req_rises;
      mem_op("b2b_lw0", EXE_LW_OP, 32'h4000, 32'h0, 32'hCAFE_0001, 1);
      mem_op("b2b_lw1", EXE_LW_OP, 32'h4000, 32'h0, 32'hCAFE_0002, 1);
      @(posedge clk); #1;
      tests++;
      if (req_rises - r0 != 2) begin
         fails++;
         $display("FAIL b2b req edges: got %0d, required 2", req_rises - r0);
      end
   endtask

   task automatic test_async_reset();
      mem_aluop = EXE_LW_OP; mem_addr = 32'h5000; mem_wd = 5'd9; mem_wreg = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      tests++;
      if (dbus_req !== 1'b1 || stallreq !== 1'b1) begin
         fails++;
         $display("FAIL arst pre: req=%b stall=%b, required 1 1", dbus_req, stallreq);
      end
      #2 rst = 1'b1;
      #1;
      tests++;
      if (dbus_req !== 1'b0 || stallreq !== 1'b0 || wb_wreg !== 1'b0 || wb_wdata !== 32'h0) begin
         fails++;
         $display("FAIL arst drop: req=%b stall=%b wreg=%b wdata=%h, required 0 0 0 0",
                  dbus_req, stallreq, wb_wreg, wb_wdata);
      end
      mem_aluop = EXE_OR_OP;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      tests++;
      if (stallreq !== 1'b0 || wb_wreg !== mem_wreg || wb_wd !== mem_wd) begin
         fails++;
         $display("FAIL arst idle: stall=%b wreg=%b wd=%0d, required 0 %b %0d",
                  stallreq, wb_wreg, wb_wd, mem_wreg, mem_wd);
      end
      mem_op("arst_lw", EXE_LW_OP, 32'h5004, 32'h0, 32'h1357_9BDF, 1);
   endtask

`ifdef MEM_MISALIGN_TRAP_EN
   task automatic test_misalign();
      int r0;
      r0 = req_rises;
      mem_aluop = EXE_LW_OP; mem_addr = 32'h3001; mem_wreg = 1'b1;
      #1;
      tests++;
      if (excp_misalign !== 1'b1 || stallreq !== 1'b0 || wb_wreg !== 1'b0) begin
         fails++;
         $display("FAIL misalign lw: excp=%b stall=%b wreg=%b, required 1 0 0",
                  excp_misalign, stallreq, wb_wreg);
      end
      @(posedge clk); #1;
      mem_aluop = EXE_SH_OP; mem_addr = 32'h3003;
      #1;
      tests++;
      if (excp_misalign !== 1'b1 || stallreq !== 1'b0 || dbus_req !== 1'b0) begin
         fails++;
         $display("FAIL misalign sh: excp=%b stall=%b req=%b, required 1 0 0",
                  excp_misalign, stallreq, dbus_req);
      end
      @(posedge clk); #1;
      mem_aluop = EXE_OR_OP;
      @(posedge clk); #1;
      tests++;
      if (req_rises != r0 || excp_misalign !== 1'b0) begin
         fails++;
         $display("FAIL misalign bus: req rises=%0d excp=%b, required 0 0", req_rises - r0, excp_misalign);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_alu();
      test_loads();
      test_stores();
      test_back_to_back();
      test_async_reset();
`ifdef MEM_MISALIGN_TRAP_EN
      test_misalign();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM pipeline stage; sits between the ex_mem pipeline register and the mem_wb register.
- Non-memory instructions pass straight through, combinationally.
- Loads and stores drive a req/ack data bus through a small FSM and assert stallreq until the access completes.
- Big-endian byte lanes; byte/halfword load extension and store lane replication are done here.

Parameters:
- ADDR_W, 32, data-bus address width.
- DATA_W, 32, register and data-bus width (fixed at 32 for this ISA).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- mem_wd  in  5  destination register address from ex_mem.
- mem_wreg  in  1  write enable from ex_mem.
- mem_wdata  in  32  ALU result from ex_mem.
- mem_aluop  in  8  operation code; load/store codes are listed in the shared package.
- mem_addr  in  32  effective address.
- mem_sdata  in  32  store data (rt value).
- wb_wd  out  5  destination register to mem_wb.
- wb_wreg  out  1  write enable to mem_wb.
- wb_wdata  out  32  result to mem_wb.
- stallreq  out  1  pipeline stall request to the ctrl block.
- dbus_req  out  1  bus request, registered.
- dbus_we  out  1  1 = write, registered.
- dbus_addr  out  ADDR_W  word-aligned address (low 2 bits 0), registered.
- dbus_sel  out  4  byte-lane enables, bit3 = bits[31:24], registered.
- dbus_wdata  out  32  write data, registered.
- dbus_ack  in  1  one-cycle completion strobe; valid only while dbus_req=1.
- dbus_rdata  in  32  read data; valid with dbus_ack.

Behaviour:
- Reset (async): FSM=IDLE; dbus_req/we/sel/addr/wdata=0; captured read data=0.
- While rst=1, the combinational outputs are forced: wb_wd=0, wb_wreg=0, wb_wdata=0, stallreq=0.
- FSM states: IDLE, WAIT, DONE.
- IDLE, non-memory op: wb_* = mem_* passthrough; stallreq=0; zero latency.
- IDLE, load/store op: stallreq=1. At the clock edge, register the bus fields, set dbus_req=1, go to WAIT.
- WAIT: stallreq=1; dbus_* held stable. When dbus_ack=1, capture dbus_rdata, clear dbus_req, go to DONE.
- dbus_ack in IDLE or DONE is ignored.
- DONE: stallreq=0; wb_wdata = extended load data (loads) or mem_wdata (stores). Stores force wb_wreg=0. Next state is IDLE unconditionally, so the same held instruction is never reissued.
- Minimum in-stage time for a memory op: 3 cycles (ack in the first WAIT cycle). No upper bound on wait.
- Back-to-back memory ops: DONE→IDLE→WAIT.
- Lane selection, addr[1:0]:
  - Byte: 00→sel 1000 (bits 31:24), 01→0100, 10→0010, 11→0001.
  - Halfword: 0x→1100, 1x→0011.
  - Word: 1111.
- Store data replication: SB = {4{b}}, SH = {2{h}}, SW = data.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
- Misaligned half/word access when MISALIGN_TRAP_EN is off: addr low bits ignored; lane chosen by addr[1] (half) or full word.
- Reset during WAIT: bus request dropped immediately; an outstanding ack is lost (the bus slave is also reset).

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN. Adds output port excp_misalign (1 bit).
- With it, in IDLE, a misaligned op (LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0):
  - no bus access; stallreq=0;
  - wb_wreg forced to 0; excp_misalign=1 combinationally for that cycle.
- Without it: no port is added, and misaligned accesses behave as described in Behaviour.

Decomposition:
- The shared defines header holds the op codes (EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP), FSM state encodings, and existing RstEnable/ZeroWord/NOPRegAddr.
- One natural sub-module, mem_lane: combinational sel/wdata generation plus load extension.

Test Plan:
- ALU op: aluop=OR, wd=3, wdata=0x1234 → same cycle wb_wd=3, wb_wdata=0x1234, wb_wreg=1, stallreq=0, dbus_req never 1.
- LB: addr 0x1001, ack after 2 WAIT cycles with rdata 0x8899AABB → dbus_addr=0x1000, sel=0100; stallreq high for 3 cycles; in DONE wb_wdata=0xFFFFFF99.
- LBU: addr 0x1003, same rdata → wb_wdata=0x000000BB. LHU at 0x1002 → 0x0000AABB. LH at 0x1000 → 0xFFFF8899.
- SH: addr 0x2002, sdata 0x1234ABCD → dbus_we=1, sel=0011, wdata=0xABCDABCD; wb_wreg=0 in DONE.
- Two consecutive LWs with immediate ack → states IDLE,WAIT,DONE,IDLE,WAIT,DONE; exactly two dbus_req rising edges.
- Async rst pulse mid-WAIT → dbus_req falls without waiting for clk, FSM=IDLE, stallreq=0. With MEM_MISALIGN_TRAP_EN: LW at 0x3001 → excp_misalign=1, no dbus_req.
